// File: rtl/muldiv_unit.sv
`timescale 1ns / 1ps
// muldiv_unit: iterative multiply/divide unit producing the HI/LO pair for
// MULTU, MULT, DIVU and DIV. Radix-2 shift-add multiplication and restoring
// division, one bit per cycle, with a start/busy/done handshake.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   -> MULT/DIV are two's complement (operand magnitudes at accept,
//                sign correction in FIX).
//   undefined -> op[0] is ignored, every op is unsigned; FIX stays as a
//                pass-through state so latency does not change.
module muldiv_unit #(
  parameter int wide = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [wide-1:0] a,
  input  logic [wide-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [wide-1:0] hi,
  output logic [wide-1:0] lo,
  output logic            div_zero
);

  localparam int cw = $clog2(wide);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [cw-1:0]   cnt;      // iteration index within RUN
  logic            is_div;   // latched op[1]
  logic            b_zero;   // divisor was zero at accept
  logic [wide-1:0] acc;      // multiply: upper product word; divide: remainder
  logic [wide-1:0] low;      // multiply: multiplier/lower word; divide: quotient
  logic [wide-1:0] opnd;     // multiplicand or divisor

`ifdef MULDIV_SIGNED_EN
  logic            sign_res; // result sign for signed ops
  logic            sign_rem; // remainder sign (dividend sign) for signed divide
  logic [2*wide-1:0] prod;
`else
  logic            unused_op0;
  assign unused_op0 = op[0];
`endif

  logic [wide-1:0] a_in;
  logic [wide-1:0] b_in;
  logic [wide:0]   mul_sum;
  logic [wide-1:0] mul_acc_nx;
  logic [wide-1:0] mul_low_nx;
  logic [wide:0]   rem_sh;
  logic [wide-1:0] div_acc_nx;
  logic [wide-1:0] div_low_nx;
  logic [wide-1:0] res_hi;
  logic [wide-1:0] res_lo;

  // Operand conditioning at accept: magnitudes for signed ops, pass-through otherwise
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_in = a;
    b_in = b;
`ifdef MULDIV_SIGNED_EN
    if (op[0]) begin
      if (a[wide-1]) a_in = -a;
      if (b[wide-1]) b_in = -b;
    end
`endif
  end

  // One iteration step for both algorithms
  always_comb begin
    // Shift-add: conditional add into the upper word with carry, then shift pair right
    mul_sum    = {1'b0, acc} + {1'b0, (low[0] ? opnd : '0)};
    mul_acc_nx = mul_sum[wide:1];
    mul_low_nx = {mul_sum[0], low[wide-1:1]};

    // Restoring divide: shift pair left, keep the difference only if non-negative
    rem_sh = {acc, low[wide-1]};
    if (rem_sh >= {1'b0, opnd}) begin
      div_acc_nx = rem_sh[wide-1:0] - opnd;
      div_low_nx = {low[wide-2:0], 1'b1};
    end else begin
      div_acc_nx = rem_sh[wide-1:0];
      div_low_nx = {low[wide-2:0], 1'b0};
    end
  end

  // Sign correction of the raw magnitude result, applied in FIX
  always_comb begin
    res_hi = acc;
    res_lo = low;
`ifdef MULDIV_SIGNED_EN
    prod = {acc, low};
    if (!is_div) begin
      if (sign_res) prod = -prod;
      res_hi = prod[2*wide-1:wide];
      res_lo = prod[wide-1:0];
    end else begin
      if (sign_res) res_lo = -low;
      if (sign_rem) res_hi = -acc;
    end
`endif
  end

  // Control FSM with registered handshake outputs and the iterative datapath
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      acc      <= '0;
      low      <= '0;
      opnd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      sign_res <= 1'b0;
      sign_rem <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div   <= op[1];
            b_zero   <= (b == '0);
            div_zero <= 1'b0;
            acc      <= '0;
            low      <= op[1] ? a_in : b_in;
            opnd     <= op[1] ? b_in : a_in;
`ifdef MULDIV_SIGNED_EN
            sign_res <= op[0] & (a[wide-1] ^ b[wide-1]);
            sign_rem <= op[0] & a[wide-1];
`endif
          end
        end
        RUN: begin
          acc <= is_div ? div_acc_nx : mul_acc_nx;
          low <= is_div ? div_low_nx : mul_low_nx;
          cnt <= cnt + cw'(1);
          if (cnt == cw'(wide - 1)) state <= FIX;
        end
        FIX: begin
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= is_div & b_zero;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns / 1ps
// Self-checking bench for muldiv_unit: directed corner cases, handshake
// timing, reset abort, and randomized ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  muldiv_unit #(.wide(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  // Reference model straight from the arithmetic definition of each op
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic [63:0] p;
    longint      sx, sy, q, r;
    bit          sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    edz = 1'b0;
    if (!o[1]) begin
      if (sgn) p = 64'(sx * sy);
      else     p = {32'd0, x} * {32'd0, y};
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 32'd0) begin
      edz = 1'b1;
      el  = 32'hFFFF_FFFF;
      eh  = x;
    end else if (sgn) begin
      q  = sx / sy;
      r  = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = x / y;
      eh = x % y;
    end
  endfunction

  // Issue one op and watch it to completion; samples on the falling edge.
  // k counts cycles after the accept edge; dcyc is the k where done was seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke_mid,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                        output int nbusy, output int dcyc, output logic busy_at_done,
                        output logic dz_k1);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    nbusy = 0; dcyc = -1; rh = 'x; rl = 'x; rdz = 'x; busy_at_done = 'x;
    dz_k1 = div_zero;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        dcyc = k; rh = hi; rl = lo; rdz = div_zero; busy_at_done = busy;
        break;
      end
      if (busy) nbusy++;
      start = (poke_mid && (k == 10 || k == 20));
      if (start) begin op = 2'($urandom); a = $urandom; b = $urandom; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rh, rl, eh, el;
    logic rdz, edz, bad, dz1;
    int nb, dc;
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9abc_def0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0)
      $display("FAIL reset_outputs got busy=%b done=%b dz=%b hi=%h lo=%h required all zero",
               busy, done, div_zero, hi, lo);
    else pass_cnt++;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle got busy=%b done=%b required 0 0", busy, done);
    else pass_cnt++;
    run_op(2'b00, 32'd123456, 32'd7891, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    model(2'b00, 32'd123456, 32'd7891, eh, el, edz);
    total_cnt++;
    if (nb !== 33 || dc !== 34 || bad !== 1'b0)
      $display("FAIL first_op_timing got busy_cycles=%0d done_cycle=%0d busy_at_done=%b required 33 34 0",
               nb, dc, bad);
    else pass_cnt++;
    total_cnt++;
    if ({rh, rl} !== {eh, el})
      $display("FAIL first_op_result got %h_%h required %h_%h", rh, rl, eh, el);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || hi !== eh || lo !== el)
      $display("FAIL done_single_pulse got done=%b hi=%h lo=%h required 0 %h %h", done, hi, lo, eh, el);
    else pass_cnt++;
  endtask

  task automatic test_multu_max;
    logic [31:0] rh, rl;
    logic rdz, bad, dz1;
    int nb, dc;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, rh, rl, rdz, nb, dc, bad, dz1);
    total_cnt++;
    if (rh !== 32'hFFFF_FFFE || rl !== 32'h0000_0001)
      $display("FAIL multu_max got %h_%h required fffffffe_00000001", rh, rl);
    else pass_cnt++;
    total_cnt++;
    if (nb !== 33 || dc !== 34)
      $display("FAIL multu_mid_start_timing got busy_cycles=%0d done_cycle=%0d required 33 34", nb, dc);
    else pass_cnt++;
  endtask

  task automatic test_mult_signed;
    logic [31:0] rh, rl, eh, el;
    logic rdz, bad, dz1;
    int nb, dc;
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFF1;
`else
    eh = 32'h0000_0004; el = 32'hFFFF_FFF1;
`endif
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    total_cnt++;
    if (rh !== eh || rl !== el)
      $display("FAIL mult_neg3x5 got %h_%h required %h_%h", rh, rl, eh, el);
    else pass_cnt++;
  endtask

  task automatic test_div_signed;
    logic [31:0] rh, rl, eh, el;
    logic rdz, bad, dz1;
    int nb, dc;
`ifdef MULDIV_SIGNED_EN
    el = 32'hFFFF_FFFD; eh = 32'hFFFF_FFFF;
`else
    el = 32'h7FFF_FFFC; eh = 32'h0000_0001;
`endif
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    total_cnt++;
    if (rl !== el || rh !== eh)
      $display("FAIL div_neg7by2 got lo=%h hi=%h required lo=%h hi=%h", rl, rh, el, eh);
    else pass_cnt++;
`ifdef MULDIV_SIGNED_EN
    el = 32'h8000_0000; eh = 32'h0000_0000;
`else
    el = 32'h0000_0000; eh = 32'h8000_0000;
`endif
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    total_cnt++;
    if (rl !== el || rh !== eh || rdz !== 1'b0)
      $display("FAIL div_minint_by_m1 got lo=%h hi=%h dz=%b required lo=%h hi=%h dz=0",
               rl, rh, rdz, el, eh);
    else pass_cnt++;
  endtask

  task automatic test_divu_zero;
    logic [31:0] rh, rl;
    logic rdz, bad, dz1;
    int nb, dc;
    run_op(2'b10, 32'h0000_0064, 32'h0000_0000, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    total_cnt++;
    if (rl !== 32'hFFFF_FFFF || rh !== 32'h0000_0064 || rdz !== 1'b1)
      $display("FAIL divu_by_zero got lo=%h hi=%h dz=%b required ffffffff 00000064 1", rl, rh, rdz);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (div_zero !== 1'b1)
      $display("FAIL div_zero_hold got %b required 1", div_zero);
    else pass_cnt++;
    run_op(2'b00, 32'd3, 32'd4, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    total_cnt++;
    if (dz1 !== 1'b0 || rdz !== 1'b0 || rl !== 32'd12)
      $display("FAIL div_zero_clear got dz_after_accept=%b dz_at_done=%b lo=%h required 0 0 0000000c",
               dz1, rdz, rl);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rh, rl, eh, el;
    logic rdz, edz, bad, dz1;
    int seen;
    int nb, dc;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);   // now in cycle N+10: iteration 10
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0)
      $display("FAIL reset_mid_op got busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    else pass_cnt++;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    total_cnt++;
    if (seen !== 0)
      $display("FAIL reset_mid_no_done got done_pulses=%0d required 0", seen);
    else pass_cnt++;
    run_op(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
    model(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, eh, el, edz);
    total_cnt++;
    if ({rh, rl} !== {eh, el} || dc !== 34)
      $display("FAIL reset_mid_restart got %h_%h done_cycle=%0d required %h_%h 34", rh, rl, dc, eh, el);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int gap;
    logic [31:0] eh, el;
    logic edz;
    // Wait until done, then hold start from the done cycle on
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 100) begin @(negedge clk); gap++; end
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd11;   // raised in the DONE cycle
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL start_in_done_ignored got busy=%b required 0", busy);
    else pass_cnt++;
    @(negedge clk);                                     // accepted from IDLE
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || gap + 2 !== 36)
      $display("FAIL back_to_back_accept got busy=%b accept_to_accept=%0d required 1 35",
               busy, gap + 1);
    else pass_cnt++;
    gap = 1;
    while (!done && gap < 100) begin @(negedge clk); gap++; end
    model(2'b00, 32'd9, 32'd11, eh, el, edz);
    total_cnt++;
    if (gap !== 34 || hi !== eh || lo !== el)
      $display("FAIL back_to_back_result got done_cycle=%0d %h_%h required 34 %h_%h", gap, hi, lo, eh, el);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] x, y, rh, rl, eh, el;
    logic [1:0] o;
    logic rdz, edz, bad, dz1;
    int nb, dc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = $urandom_range(0, 20);
      if (i % 8 == 2) x = {1'b1, 31'($urandom_range(0, 5))};
      if (o[1] && y == 32'd0 && (o[0] || i % 3 != 0)) y = 32'd3;
      run_op(o, x, y, 1'b0, rh, rl, rdz, nb, dc, bad, dz1);
      model(o, x, y, eh, el, edz);
      total_cnt++;
      if ({rh, rl, rdz} !== {eh, el, edz} || dc !== 34 || nb !== 33)
        $display("FAIL random_%0d op=%b a=%h b=%h got hi=%h lo=%h dz=%b t=%0d required hi=%h lo=%h dz=%b t=34",
                 i, o, x, y, rh, rl, rdz, dc, eh, el, edz);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_divu_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO pair for MULT, MULTU, DIV and DIVU. It sits downstream of the register-file read ports and upstream of the HI/LO registers, driven by the auxiliary decoder's multiply/divide strobe. It uses radix-2 shift-add multiplication and restoring division. It exposes a start/busy/done handshake so the datapath can stall on MFHI/MFLO until the result is valid.

## Interface
- wide, 32, operand width; hi/lo are each `wide` bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- op  in  2  operation, latched at accept: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  wide  multiplicand or dividend (rs), latched at accept.
- b  in  wide  multiplier or divisor (rt), latched at accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo are valid from this cycle onward.
- hi  out  wide  MULT: upper product word. DIV: remainder.
- lo  out  wide  MULT: lower product word. DIV: quotient.
- div_zero  out  1  asserted with done when a divide had b == 0; cleared on the next accept.

## Operation
- Reset value of every output (busy, done, div_zero, hi, lo) is 0. The FSM resets to IDLE and the iteration counter to 0.
- States and transitions:
  - IDLE → RUN when start = 1.
  - RUN → FIX after `wide` iterations.
  - FIX → DONE.
  - DONE → IDLE.
- Accept (IDLE with start = 1):
  - Latch op, a and b.
  - For signed ops, latch |a| and |b|, plus the result sign (a[wide-1] ^ b[wide-1]) and the remainder sign (a[wide-1]).
  - For unsigned ops, the operands pass through unchanged.
- RUN, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper accumulator (carry kept, wide+1 bits). Then shift the {acc, multiplier} pair right by 1.
- RUN, divide: each cycle, shift {rem, quo} left by 1, then trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore rem.
- FIX:
  - Signed multiply with negative result sign: negate the 2·wide product.
  - Signed divide: negate the quotient if the result sign is 1; negate the remainder if the dividend sign is 1.
  - Register the result into hi/lo.
- DONE: done = 1 for exactly one cycle. hi/lo then hold until the next completion.
- Arithmetic rules:
  - Results are truncated to wide bits per word.
  - DIV of most-negative by −1 gives lo = most-negative and hi = 0, with no trap.
- Divide by zero: no special path. The algorithm yields lo = all ones and hi = the dividend magnitude, after FIX sign correction for DIV. div_zero = 1.
- start while not in IDLE is ignored; no queuing.
- start asserted in the DONE cycle is ignored. Software must re-request in IDLE.
- rst in any state aborts the operation and returns everything to reset values in the next cycle.

## Timing
- Accept at edge N: busy = 1 from cycle N+1 through N+wide+1.
- The RUN iterations occupy cycles N+1..N+wide, and FIX occupies cycle N+wide+1.
- done = 1 and hi/lo update in cycle N+wide+2, with busy = 0 in that cycle. For wide = 32, that is 34 cycles after accept.
- The earliest next accept is in cycle N+wide+3, giving a throughput of one operation per wide+3 cycles.
- hi/lo never change except on the done cycle and on rst.
- Handshake: the datapath holds op/a/b stable only during the accept cycle.

## Configuration
- MULDIV_SIGNED_EN defined:
  - MULT and DIV perform two's-complement operation: abs/negate logic plus the FIX sign correction.
- MULDIV_SIGNED_EN undefined:
  - op[0] is ignored and all ops are unsigned.
  - FIX is kept as a pass-through state, so latency is identical.
  - The sign registers and negators are removed.

## Test plan
- Reset with start held high: after rst, outputs are 0 and the unit is in IDLE. Release rst and pulse start in a later cycle → busy for exactly 33 cycles, done in the 34th.
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. A start pulse mid-operation is ignored, verified by an unchanged result and unchanged timing.
- MULT a=FFFFFFFD (−3), b=00000005 → hi=FFFFFFFF, lo=FFFFFFF1. Without MULDIV_SIGNED_EN → hi=00000004, lo=FFFFFFF1.
- DIV a=FFFFFFF9 (−7), b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=00000000.
- DIVU a=00000064, b=0 → lo=FFFFFFFF, hi=00000064, div_zero=1. The next accept clears div_zero.
- Assert rst at iteration 10 of a MULTU → next cycle busy=0, hi=lo=0, and no done pulse. A new start then completes normally.
